// File: rtl/ysyx_25050147_alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// ysyx_25050147_alu_arbiter_if
//   Request/response bus between the two ALU requesters and the ALU arbiter.
//   Both ports share the one bus. Bit i of each 2-bit vector belongs to port i.
//   Port 0 is the EXU. Port 1 is the branch/AGU side path.
//
//   req_valid  : port i presents an operation
//   req_ready  : port i operation accepted this cycle
//   reqN_*     : operation, operands and is_beq flag of port N
//   rsp_valid  : result for port i is valid
//   rsp_ready  : port i consumes its result
//   rsp_data   : registered ALU result, shared by both ports
//
//   Modports:
//   - master : requester side.
//   - slave  : arbiter side.
// ----------------------------------------------------------------------------
interface ysyx_25050147_alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req0_op;
  logic [3:0]  req1_op;
  logic [31:0] req0_src1;
  logic [31:0] req1_src1;
  logic [31:0] req0_src2;
  logic [31:0] req1_src2;
  logic        req0_beq;
  logic        req1_beq;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req0_op, req1_op, req0_src1, req1_src1,
           req0_src2, req1_src2, req0_beq, req1_beq, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req0_op, req1_op, req0_src1, req1_src1,
           req0_src2, req1_src2, req0_beq, req1_beq, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ysyx_25050147_alu_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_25050147_alu_arbiter
//   Shares one combinational ALU between two requesters.
//   It accepts one operation at a time and registers the operands into the ALU.
//   It captures the ALU result and returns it on the winning port's response
//   handshake.
//
//   Flow: IDLE (accept) -> EXEC (ALU evaluates, result captured) -> RESP
//   (result offered), so the peak rate is one operation every 3 cycles.
//
//   Ports:
//   - clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   - bus (slave)       : request/response handshakes of both requesters
//   - alu_op/src1/src2/is_beq : registered operation driven into the ALU
//   - alu_fresult       : combinational ALU result
//   - busy              : an operation is in flight (EXEC or RESP)
//   - gnt_cnt0/gnt_cnt1 : accepted-operation counters, wrap modulo 2^CNT_W
//
//   Parameters:
//   - RR_EN : 1 = round-robin on contention, 0 = port 0 always wins
//   - CNT_W : width of the grant counters
// ----------------------------------------------------------------------------
module ysyx_25050147_alu_arbiter #(
  parameter int unsigned RR_EN = 32'd1,
  parameter int unsigned CNT_W = 32'd32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  ysyx_25050147_alu_arbiter_if.slave       bus,
  output logic [3:0]                       alu_op,
  output logic [31:0]                      alu_src1,
  output logic [31:0]                      alu_src2,
  output logic                             alu_is_beq,
  input  logic [31:0]                      alu_fresult,
  output logic                             busy,
  output logic [CNT_W-1:0]                 gnt_cnt0,
  output logic [CNT_W-1:0]                 gnt_cnt1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q,     state_d;
  logic              last_q,      last_d;      // port granted most recently
  logic              gnt_q,       gnt_d;       // port owning the in-flight op
  logic [3:0]        op_q,        op_d;
  logic [31:0]       src1_q,      src1_d;
  logic [31:0]       src2_q,      src2_d;
  logic              beq_q,       beq_d;
  logic [31:0]       rsp_data_q,  rsp_data_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic              busy_q,      busy_d;
  logic [CNT_W-1:0]  cnt0_q,      cnt0_d;
  logic [CNT_W-1:0]  cnt1_q,      cnt1_d;
  logic              win_s;
  logic [1:0]        req_ready_s;

  // Next-state, arbitration and handshake decode
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    op_d        = op_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    beq_d       = beq_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    win_s       = 1'b0;
    req_ready_s = 2'b00;

    case (state_q)
      ST_IDLE: begin
        // On contention the port that was not served last wins (round-robin),
        // or port 0 always wins when fixed priority is selected.
        if (bus.req_valid == 2'b11) begin
          if (RR_EN != 32'd0) begin
            win_s = ~last_q;
          end else begin
            win_s = 1'b0;
          end
        end else if (bus.req_valid == 2'b10) begin
          win_s = 1'b1;
        end else begin
          win_s = 1'b0;
        end

        // Ready is only raised toward a valid winner, so any valid is a handshake
        if (bus.req_valid != 2'b00) begin
          req_ready_s = win_s ? 2'b10 : 2'b01;
          state_d     = ST_EXEC;
          gnt_d       = win_s;
          last_d      = win_s;
          busy_d      = 1'b1;
          if (win_s) begin
            op_d   = bus.req1_op;
            src1_d = bus.req1_src1;
            src2_d = bus.req1_src2;
            beq_d  = bus.req1_beq;
            cnt1_d = cnt1_q + CNT_W'(1);
          end else begin
            op_d   = bus.req0_op;
            src1_d = bus.req0_src1;
            src2_d = bus.req0_src2;
            beq_d  = bus.req0_beq;
            cnt0_d = cnt0_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_EXEC: begin
        // Operands have been stable for a full cycle; take the ALU result
        rsp_data_d  = alu_fresult;
        rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        // Only the granted port's rsp_ready completes the response
        if (bus.rsp_ready[gnt_q]) begin
          rsp_valid_d = 2'b00;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        rsp_valid_d = 2'b00;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      op_q        <= 4'd0;
      src1_q      <= 32'd0;
      src2_q      <= 32'd0;
      beq_q       <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_valid_q <= 2'b00;
      busy_q      <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      op_q        <= op_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      beq_q       <= beq_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign alu_op        = op_q;
  assign alu_src1      = src1_q;
  assign alu_src2      = src2_q;
  assign alu_is_beq    = beq_q;
  assign busy          = busy_q;
  assign gnt_cnt0      = cnt0_q;
  assign gnt_cnt1      = cnt1_q;

endmodule

// File: tb/tb_ysyx_25050147_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_25050147_alu_arbiter
//   Directed bench for the ALU arbiter.
//   - DUT A uses round-robin with 32-bit counters.
//   - DUT B uses fixed priority with 2-bit counters, so that counter wrap
//     is reachable.
//   A tiny ALU model closes the loop on each DUT: op 0000 adds, op 1000
//   subtracts. With beq set, op 0000 returns a==b and op 0001 returns a!=b.
// ----------------------------------------------------------------------------
module tb_ysyx_25050147_alu_arbiter;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;

  int n_cmp;
  int n_err;

  ysyx_25050147_alu_arbiter_if ifa ();
  ysyx_25050147_alu_arbiter_if ifb ();

  logic [1:0]  req_valid_v [2];
  logic [1:0]  rsp_ready_v [2];
  logic [3:0]  p_op   [2];
  logic [31:0] p_src1 [2];
  logic [31:0] p_src2 [2];
  logic        p_beq  [2];

  logic [3:0]  alu_op_a,   alu_op_b;
  logic [31:0] alu_src1_a, alu_src1_b;
  logic [31:0] alu_src2_a, alu_src2_b;
  logic        alu_beq_a,  alu_beq_b;
  logic [31:0] alu_res_a,  alu_res_b;
  logic        busy_a,     busy_b;
  logic [31:0] cnt0_a,     cnt1_a;
  logic [1:0]  cnt0_b,     cnt1_b;
  logic        saw_b_rdy1;

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic beq);
    if (beq) begin
      if (op == 4'b0000) return {31'd0, (a == b)};
      else               return {31'd0, (a != b)};
    end
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_res_a = alu_model(alu_op_a, alu_src1_a, alu_src2_a, alu_beq_a);
  assign alu_res_b = alu_model(alu_op_b, alu_src1_b, alu_src2_b, alu_beq_b);

  assign ifa.req_valid = req_valid_v[0];
  assign ifb.req_valid = req_valid_v[1];
  assign ifa.rsp_ready = rsp_ready_v[0];
  assign ifb.rsp_ready = rsp_ready_v[1];
  assign ifa.req0_op = p_op[0];   assign ifb.req0_op = p_op[0];
  assign ifa.req1_op = p_op[1];   assign ifb.req1_op = p_op[1];
  assign ifa.req0_src1 = p_src1[0]; assign ifb.req0_src1 = p_src1[0];
  assign ifa.req1_src1 = p_src1[1]; assign ifb.req1_src1 = p_src1[1];
  assign ifa.req0_src2 = p_src2[0]; assign ifb.req0_src2 = p_src2[0];
  assign ifa.req1_src2 = p_src2[1]; assign ifb.req1_src2 = p_src2[1];
  assign ifa.req0_beq = p_beq[0]; assign ifb.req0_beq = p_beq[0];
  assign ifa.req1_beq = p_beq[1]; assign ifb.req1_beq = p_beq[1];

  ysyx_25050147_alu_arbiter #(.RR_EN(32'd1), .CNT_W(32'd32)) u_dut_a (
    .clk(clk), .rst_n(rst_a_n), .bus(ifa.slave),
    .alu_op(alu_op_a), .alu_src1(alu_src1_a), .alu_src2(alu_src2_a),
    .alu_is_beq(alu_beq_a), .alu_fresult(alu_res_a), .busy(busy_a),
    .gnt_cnt0(cnt0_a), .gnt_cnt1(cnt1_a)
  );

  ysyx_25050147_alu_arbiter #(.RR_EN(32'd0), .CNT_W(32'd2)) u_dut_b (
    .clk(clk), .rst_n(rst_b_n), .bus(ifb.slave),
    .alu_op(alu_op_b), .alu_src1(alu_src1_b), .alu_src2(alu_src2_b),
    .alu_is_beq(alu_beq_b), .alu_fresult(alu_res_b), .busy(busy_b),
    .gnt_cnt0(cnt0_b), .gnt_cnt1(cnt1_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-priority DUT must never offer ready to port 1
  always @(negedge clk) begin
    if (ifb.req_ready[1]) saw_b_rdy1 = 1'b1;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] get_rdy(input int sel);
    return (sel == 0) ? ifa.req_ready : ifb.req_ready;
  endfunction
  function automatic logic [1:0] get_rv(input int sel);
    return (sel == 0) ? ifa.rsp_valid : ifb.rsp_valid;
  endfunction
  function automatic logic [31:0] get_rd(input int sel);
    return (sel == 0) ? ifa.rsp_data : ifb.rsp_data;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  task automatic set_port(input int p, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic beq);
    p_op[p] = op; p_src1[p] = a; p_src2[p] = b; p_beq[p] = beq;
  endtask

  task automatic reset_a();
    rst_a_n = 1'b0;
    step();
    step();
    rst_a_n = 1'b1;
    step();
  endtask

  // One complete transaction: present vmask, expect winner, expect data
  task automatic do_txn(input int sel, input logic [1:0] vmask, input int winner,
                        input logic [31:0] exp_data, input string tag);
    logic [1:0] oh;
    oh = (winner == 1) ? 2'b10 : 2'b01;
    req_valid_v[sel] = vmask;
    #1;
    check_val({tag, ".ready"}, get_rdy(sel), oh);
    step();
    req_valid_v[sel] = vmask & ~oh;
    check_val({tag, ".busy_exec"}, get_busy(sel), 1'b1);
    check_val({tag, ".ready_exec"}, get_rdy(sel), 2'b00);
    check_val({tag, ".rv_exec"}, get_rv(sel), 2'b00);
    step();
    check_val({tag, ".rv_resp"}, get_rv(sel), oh);
    check_val({tag, ".data"}, get_rd(sel), exp_data);
    rsp_ready_v[sel] = oh;
    step();
    rsp_ready_v[sel] = 2'b00;
    check_val({tag, ".rv_idle"}, get_rv(sel), 2'b00);
    check_val({tag, ".busy_idle"}, get_busy(sel), 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    saw_b_rdy1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid_v[i] = 2'b00;
      rsp_ready_v[i] = 2'b00;
      set_port(i, 4'd0, 32'd0, 32'd0, 1'b0);
    end
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    step();
    step();
    check_val("rst.rv", ifa.rsp_valid, 2'b00);
    check_val("rst.busy", busy_a, 1'b0);
    check_val("rst.cnt0", cnt0_a, 32'd0);
    check_val("rst.data", ifa.rsp_data, 32'd0);
    check_val("rst.src1", alu_src1_a, 32'd0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    step();

    // 1: single op on port 0
    set_port(0, 4'b0000, 32'd5, 32'd3, 1'b0);
    do_txn(0, 2'b01, 0, 32'd8, "t1");
    check_val("t1.cnt0", cnt0_a, 32'd1);
    check_val("t1.src1_hold", alu_src1_a, 32'd5);
    check_val("t1.src2_hold", alu_src2_a, 32'd3);

    // 2: contention after reset, round-robin
    reset_a();
    set_port(0, 4'b0000, 32'd7, 32'd1, 1'b0);
    set_port(1, 4'b1000, 32'd7, 32'd1, 1'b0);
    do_txn(0, 2'b11, 0, 32'd8, "t2a");
    do_txn(0, 2'b10, 1, 32'd6, "t2b");
    do_txn(0, 2'b11, 0, 32'd8, "t2c");
    req_valid_v[0] = 2'b00;
    check_val("t2.cnt0", cnt0_a, 32'd2);
    check_val("t2.cnt1", cnt1_a, 32'd1);

    // 3: fixed priority, 2-bit counter wraps on the 4th op
    set_port(0, 4'b0000, 32'd1, 32'd2, 1'b0);
    set_port(1, 4'b1000, 32'd9, 32'd4, 1'b0);
    do_txn(1, 2'b11, 0, 32'd3, "t3a");
    do_txn(1, 2'b11, 0, 32'd3, "t3b");
    do_txn(1, 2'b11, 0, 32'd3, "t3c");
    check_val("t3.cnt0", cnt0_b, 2'd3);
    do_txn(1, 2'b11, 0, 32'd3, "t3d");
    req_valid_v[1] = 2'b00;
    check_val("t3.cnt0_wrap", cnt0_b, 2'd0);
    check_val("t3.cnt1", cnt1_b, 2'd0);
    check_val("t3.no_rdy1", saw_b_rdy1, 1'b0);

    // 4: beq compare on port 1
    set_port(1, 4'b0000, 32'h1234, 32'h1234, 1'b1);
    do_txn(0, 2'b10, 1, 32'd1, "t4a");
    set_port(1, 4'b0001, 32'h1234, 32'h1234, 1'b1);
    do_txn(0, 2'b10, 1, 32'd0, "t4b");
    check_val("t4.cnt1", cnt1_a, 32'd3);
    check_val("t4.beq_hold", alu_beq_a, 1'b1);

    // 5: stall in RESP with port 1 waiting; port 1 rsp_ready is ignored
    set_port(0, 4'b0000, 32'd2, 32'd2, 1'b0);
    set_port(1, 4'b1000, 32'd10, 32'd3, 1'b0);
    req_valid_v[0] = 2'b11;
    #1;
    check_val("t5.ready", ifa.req_ready, 2'b01);
    step();
    req_valid_v[0] = 2'b10;
    step();
    rsp_ready_v[0] = 2'b10;
    for (int i = 0; i < 10; i++) begin
      check_val("t5.rv_hold", ifa.rsp_valid, 2'b01);
      check_val("t5.data_hold", ifa.rsp_data, 32'd4);
      check_val("t5.ready_hold", ifa.req_ready, 2'b00);
      step();
      rsp_ready_v[0] = 2'b00;
    end
    rsp_ready_v[0] = 2'b01;
    step();
    rsp_ready_v[0] = 2'b00;
    check_val("t5.rv_idle", ifa.rsp_valid, 2'b00);
    do_txn(0, 2'b10, 1, 32'd7, "t5b");
    req_valid_v[0] = 2'b00;
    check_val("t5.cnt0", cnt0_a, 32'd3);
    check_val("t5.cnt1", cnt1_a, 32'd4);

    // 6: reset while in EXEC discards the op
    set_port(0, 4'b0000, 32'd1, 32'd1, 1'b0);
    req_valid_v[0] = 2'b01;
    step();
    req_valid_v[0] = 2'b00;
    check_val("t6.busy_exec", busy_a, 1'b1);
    rst_a_n = 1'b0;
    #1;
    check_val("t6.busy_rst", busy_a, 1'b0);
    check_val("t6.rv_rst", ifa.rsp_valid, 2'b00);
    check_val("t6.cnt0_rst", cnt0_a, 32'd0);
    check_val("t6.cnt1_rst", cnt1_a, 32'd0);
    step();
    check_val("t6.rv_later", ifa.rsp_valid, 2'b00);
    rst_a_n = 1'b1;
    step();
    do_txn(0, 2'b01, 0, 32'd2, "t6b");
    check_val("t6.cnt0", cnt0_a, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
